mem_port_arbiter: RTL and testbench

Shares a single-ported unified memory between the instruction-fetch port and the MEM-stage data port of the RV32I pipeline. Each requester sees a simple request/ready handshake; the memory side sees one registered transaction at a time. The block has data-over-fetch priority with a starvation guard, plus a watchdog that aborts a transaction if the memory never answers. The pipeline stalls PC/IF_ID on `if_req && !if_ready` and stalls EX_MEM/MEM_WB on `d_req && !d_ready`.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and the MEM-stage data port.
// Data has priority, a streak counter guarantees fetch progress, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);
    localparam logic [2:0] F3_WORD    = 3'b010;

    state_t            state, state_nxt;
    logic [3:0]        streak, streak_nxt;
    logic [7:0]        wd_cnt, wd_cnt_nxt;
    logic              own_d, own_d_nxt;
    logic              err_q, err_nxt;
    logic              grant, grant_d;
    logic              capture;
    logic [DATA_W-1:0] cap_data;

    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    function automatic logic [3:0] streak_sat_inc(input logic [3:0] s);
        if (s >= STREAK_MAX)
            return STREAK_MAX;
        return s + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            streak <= '0;
            wd_cnt <= '0;
            own_d  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            wd_cnt <= wd_cnt_nxt;
            own_d  <= own_d_nxt;
            err_q  <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        wd_cnt_nxt = wd_cnt;
        own_d_nxt  = own_d;
        err_nxt    = err_q;
        grant      = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;
        cap_data   = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_funct3 = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if_ready   = 1'b0;
        d_ready    = 1'b0;
        err        = 1'b0;
        busy       = (state != IDLE);
        if_rdata   = if_rdata_q;
        d_rdata    = d_rdata_q;

        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    grant      = 1'b1;
                    // Fetch only overtakes a pending data request once its wait streak is exhausted
                    grant_d    = d_req && !(if_req && (streak == STREAK_MAX));
                    own_d_nxt  = grant_d;
                    wd_cnt_nxt = '0;
                    err_nxt    = 1'b0;
                    streak_nxt = (grant_d && if_req) ? streak_sat_inc(streak) : 4'd0;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                mem_req    = 1'b1;
                mem_we     = lat_we;
                mem_funct3 = lat_f3;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
                wd_cnt_nxt = wd_cnt + 8'd1;
                if (mem_ready) begin
                    capture   = 1'b1;
                    cap_data  = lat_we ? '0 : mem_rdata;
                    state_nxt = RESP;
                end else if (wd_cnt == WD_LAST) begin
                    capture   = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if_ready   = !own_d;
                d_ready    = own_d;
                err        = err_q;
                wd_cnt_nxt = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are frozen at grant so the memory sees stable values for the whole access
    always_ff @(posedge clk) begin
        if (grant) begin
            lat_we    <= grant_d ? d_we : 1'b0;
            lat_f3    <= grant_d ? d_funct3 : F3_WORD;
            lat_addr  <= grant_d ? d_addr : if_addr;
            lat_wdata <= grant_d ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (capture) begin
            if (own_d)
                d_rdata_q <= cap_data;
            else
                if_rdata_q <= cap_data;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the arbitration rules and a simple memory array.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MAX_STREAK = 4;
    localparam int TIMEOUT    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [logic [31:0]];

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
        mem_ready = 0; mem_rdata = '0;
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic test_reset();
        clear_inputs();
        if_req = 1; if_addr = 32'h44;
        #3;
        checks++;
        if ({mem_req, mem_we, mem_funct3, mem_addr, mem_wdata, if_ready, if_rdata,
             d_ready, d_rdata, err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b busy=%b if_ready=%b d_ready=%b err=%b mem_addr=%h want all zero",
                     mem_req, busy, if_ready, d_ready, err, mem_addr);
        end
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_ignores_req: busy=%b mem_req=%b want 0 0", busy, mem_req);
        end
        if_req = 0;
        rst = 1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h10;
        tick();
        checks++;
        if (mem_req !== 1 || mem_addr !== 32'h10 || mem_we !== 0 || mem_funct3 !== 3'b010 || busy !== 1) begin
            errors++;
            $display("FAIL fetch_busy: mem_req=%b addr=%h we=%b f3=%b busy=%b want 1 10 0 010 1",
                     mem_req, mem_addr, mem_we, mem_funct3, busy);
        end
        mem_ready = 1; mem_rdata = 32'h0050_0093;
        tick();
        mem_ready = 0; if_req = 0;
        checks++;
        if (if_ready !== 1 || if_rdata !== 32'h0050_0093 || d_ready !== 0 || err !== 0 || mem_req !== 0) begin
            errors++;
            $display("FAIL fetch_resp: if_ready=%b if_rdata=%h d_ready=%b err=%b mem_req=%b want 1 00500093 0 0 0",
                     if_ready, if_rdata, d_ready, err, mem_req);
        end
        tick();
        checks++;
        if (busy !== 0 || if_ready !== 0) begin
            errors++;
            $display("FAIL fetch_idle: busy=%b if_ready=%b want 0 0", busy, if_ready);
        end
    endtask

    task automatic test_contention();
        logic exp_f;
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 0; d_funct3 = 3'b100; d_addr = 32'h300;
        for (int n = 0; n < 10; n++) begin
            exp_f = (n % 5 == 4);
            tick();
            checks++;
            if (mem_req !== 1 || mem_addr !== (exp_f ? 32'h200 : 32'h300)) begin
                errors++;
                $display("FAIL contention_grant%0d: mem_req=%b mem_addr=%h want 1 %h",
                         n, mem_req, mem_addr, exp_f ? 32'h200 : 32'h300);
            end
            mem_ready = 1; mem_rdata = 32'hC000_0000 + n;
            tick();
            mem_ready = 0;
            if (n == 9) begin
                if_req = 0; d_req = 0;
            end
            checks++;
            if (if_ready !== exp_f || d_ready !== !exp_f ||
                (exp_f ? if_rdata : d_rdata) !== 32'hC000_0000 + n) begin
                errors++;
                $display("FAIL contention_resp%0d: if_ready=%b d_ready=%b if_rdata=%h d_rdata=%h want if_ready=%b data=%h",
                         n, if_ready, d_ready, if_rdata, d_rdata, exp_f, 32'hC000_0000 + n);
            end
            tick();
        end
    endtask

    task automatic test_store_wait();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b000;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem_req !== 1 || mem_we !== 1 || mem_funct3 !== 3'b000 ||
                mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL store_busy%0d: req=%b we=%b f3=%b addr=%h wdata=%h want 1 1 000 100 deadbeef",
                         k, mem_req, mem_we, mem_funct3, mem_addr, mem_wdata);
            end
            if (k == 0) begin
                d_addr = 32'hBAD0; d_wdata = 32'h1111_2222; d_funct3 = 3'b001;
            end
            if (k == 2) begin
                mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
            end
            tick();
        end
        mem_ready = 0; d_req = 0;
        checks++;
        if (d_ready !== 1 || d_rdata !== '0 || err !== 0 || if_ready !== 0) begin
            errors++;
            $display("FAIL store_resp: d_ready=%b d_rdata=%h err=%b if_ready=%b want 1 0 0 0",
                     d_ready, d_rdata, err, if_ready);
        end
        tick();
    endtask

    task automatic test_timeout();
        d_req = 1; d_we = 0; d_addr = 32'h40; d_funct3 = 3'b010;
        mem_rdata = 32'h7777_7777;
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            checks++;
            if (mem_req !== 1 || d_ready !== 0) begin
                errors++;
                $display("FAIL timeout_busy%0d: mem_req=%b d_ready=%b want 1 0", k, mem_req, d_ready);
            end
            tick();
        end
        d_req = 0;
        checks++;
        if (mem_req !== 0 || d_ready !== 1 || err !== 1 || d_rdata !== '0) begin
            errors++;
            $display("FAIL timeout_resp: mem_req=%b d_ready=%b err=%b d_rdata=%h want 0 1 1 0",
                     mem_req, d_ready, err, d_rdata);
        end
        tick();
        checks++;
        if (busy !== 0 || err !== 0 || d_ready !== 0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%b err=%b d_ready=%b want 0 0 0", busy, err, d_ready);
        end
        mem_rdata = '0;
    endtask

    task automatic test_stray_ready();
        if_req = 1; if_addr = 32'h20;
        tick();
        mem_ready = 1; mem_rdata = 32'h1234;
        tick();
        mem_ready = 0; if_req = 0;
        checks++;
        if (if_ready !== 1 || if_rdata !== 32'h1234) begin
            errors++;
            $display("FAIL stray_setup: if_ready=%b if_rdata=%h want 1 00001234", if_ready, if_rdata);
        end
        tick();
        mem_ready = 1; mem_rdata = 32'h9999;
        tick();
        mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (if_ready !== 0 || d_ready !== 0 || busy !== 0 || mem_req !== 0) begin
                errors++;
                $display("FAIL stray_ready%0d: if_ready=%b d_ready=%b busy=%b mem_req=%b want 0 0 0 0",
                         k, if_ready, d_ready, busy, mem_req);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        if_req = 1; if_addr = 32'h80;
        tick();
        tick();
        #2 rst = 0;
        #1;
        checks++;
        if (mem_req !== 0 || busy !== 0 || if_ready !== 0) begin
            errors++;
            $display("FAIL reset_mid_busy: mem_req=%b busy=%b if_ready=%b want 0 0 0", mem_req, busy, if_ready);
        end
        if_req = 0;
        tick();
        rst = 1;
        for (int k = 0; k < 6; k++) begin
            mem_ready = (k == 1); mem_rdata = 32'hABCD;
            tick();
            checks++;
            if (if_ready !== 0 || d_ready !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL reset_late_ready%0d: if_ready=%b d_ready=%b busy=%b want 0 0 0",
                         k, if_ready, d_ready, busy);
            end
        end
        mem_ready = 0;
    endtask

    task automatic test_random();
        logic        pend_if, pend_d, d_w, win_d;
        logic [31:0] if_a, d_a, d_wd, exp_addr, exp_rd, rsp;
        logic [2:0]  d_f3;
        int          owed, w;
        owed = 0;
        pend_if = 1; if_a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        pend_d = 1; d_w = 1'($urandom); d_a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        d_wd = $urandom; d_f3 = 3'($urandom);
        for (int n = 0; n < 60; n++) begin
            if_req = pend_if; if_addr = if_a;
            d_req = pend_d; d_we = d_w; d_addr = d_a; d_wdata = d_wd; d_funct3 = d_f3;
            win_d = pend_d && !(pend_if && owed == MAX_STREAK);
            exp_addr = win_d ? d_a : if_a;
            w = $urandom_range(0, 3);
            tick();
            for (int k = 0; k <= w; k++) begin
                checks++;
                if (mem_req !== 1 || mem_addr !== exp_addr || mem_we !== (win_d && d_w) ||
                    mem_funct3 !== (win_d ? d_f3 : 3'b010) ||
                    (win_d && d_w && mem_wdata !== d_wd)) begin
                    errors++;
                    $display("FAIL rand_busy%0d: req=%b addr=%h we=%b f3=%b wdata=%h want addr=%h we=%b data_owner=%b",
                             n, mem_req, mem_addr, mem_we, mem_funct3, mem_wdata, exp_addr, win_d && d_w, win_d);
                end
                if (k == w) begin
                    rsp = (win_d && d_w) ? $urandom : mem_read(exp_addr);
                    mem_ready = 1; mem_rdata = rsp;
                end
                tick();
            end
            mem_ready = 0;
            exp_rd = (win_d && d_w) ? 32'd0 : mem_read(exp_addr);
            if (win_d && d_w)
                mem_model[d_a] = d_wd;
            checks++;
            if (if_ready !== !win_d || d_ready !== win_d || err !== 0 ||
                (win_d ? d_rdata : if_rdata) !== exp_rd) begin
                errors++;
                $display("FAIL rand_resp%0d: if_ready=%b d_ready=%b err=%b if_rdata=%h d_rdata=%h want data_owner=%b data=%h",
                         n, if_ready, d_ready, err, if_rdata, d_rdata, win_d, exp_rd);
            end
            owed = win_d ? (pend_if ? ((owed + 1 > MAX_STREAK) ? MAX_STREAK : owed + 1) : 0) : 0;
            if (win_d) begin
                pend_d = ($urandom_range(0, 9) < 8);
                d_w = 1'($urandom); d_a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                d_wd = $urandom; d_f3 = 3'($urandom);
            end else begin
                pend_if = ($urandom_range(0, 9) < 6);
                if_a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!pend_if && !pend_d)
                pend_if = 1;
            if_req = pend_if; if_addr = if_a;
            d_req = pend_d; d_we = d_w; d_addr = d_a; d_wdata = d_wd; d_funct3 = d_f3;
            tick();
            checks++;
            if (busy !== 0 || if_ready !== 0 || d_ready !== 0) begin
                errors++;
                $display("FAIL rand_idle%0d: busy=%b if_ready=%b d_ready=%b want 0 0 0", n, busy, if_ready, d_ready);
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store_wait();
        test_timeout();
        test_stray_ready();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
